// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr
//
// Round-robin bus arbiter with a tenure limit and split parking.
//
// A single owner holds a registered one-hot grant. Ownership is lost when any
// of the following happens:
//   - the owner drops its request;
//   - the slave splits the owner's transfer;
//   - the owner reaches the tenure limit while another master is waiting.
// A split owner is parked in split_mask and stays ineligible until the slave
// pulses its split_release bit.
//
// Parameters
//   NUM_MASTERS  number of requesting masters (2..16)
//   MAX_HOLD     tenure limit in cycles when others wait; 0 disables it
//   SEL_W        derived width of m_select
//
// Ports
//   clk            clock, rising edge
//   rst_n          synchronous active-low reset
//   req            per-master request level
//   split          slave splits the current owner's transfer
//   split_release  per-master strobe that unparks a split master
//   grant          registered one-hot-or-zero grant
//   grant_valid    high while a grant bit is set
//   m_select       index of the granted master, 0 when idle
//   split_mask     masters currently parked by split
// -----------------------------------------------------------------------------
module bus_arbiter_rr #(
  parameter int  NUM_MASTERS = 4,
  parameter int  MAX_HOLD    = 16,
  localparam int SEL_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   split,
  input  logic [NUM_MASTERS-1:0] split_release,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   grant_valid,
  output logic [SEL_W-1:0]       m_select,
  output logic [NUM_MASTERS-1:0] split_mask
);

  // The counter only has to reach MAX_HOLD-1, where it saturates.
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST =
    (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : {CNT_W{1'b1}};
  localparam bit HOLD_EN = (MAX_HOLD > 0);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t                 state_reg, state_next;
  logic [NUM_MASTERS-1:0] grant_reg, grant_next;
  logic                   grant_valid_reg, grant_valid_next;
  logic [SEL_W-1:0]       sel_reg, sel_next;
  logic [NUM_MASTERS-1:0] mask_reg, mask_next;
  logic [CNT_W-1:0]       hold_reg, hold_next;
  // Index at which the next round-robin search begins (last owner + 1).
  logic [SEL_W-1:0]       ptr_reg, ptr_next;

  logic [NUM_MASTERS-1:0] cand;
  logic                   pick_found;
  logic [SEL_W-1:0]       pick_idx;
  logic [NUM_MASTERS-1:0] pick_onehot;
  logic                   owner_req;
  logic                   do_take;
  logic                   do_idle;

  // Candidates are the unparked requesters, minus the current owner. The
  // owner's grant is zero in IDLE, so one expression serves both states.
  assign cand      = req & ~mask_reg & ~grant_reg;
  assign owner_req = req[sel_reg];

  // Rotating priority search starting at ptr_reg.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!pick_found && cand[(int'(ptr_reg) + i) % NUM_MASTERS]) begin
        pick_found = 1'b1;
        pick_idx   = SEL_W'((int'(ptr_reg) + i) % NUM_MASTERS);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_onehot
    assign pick_onehot[gi] = (pick_idx == SEL_W'(gi));
  end

  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    grant_valid_next = grant_valid_reg;
    sel_next         = sel_reg;
    hold_next        = hold_reg;
    ptr_next         = ptr_reg;
    // Releases apply every cycle; a same-cycle split of the owner is OR-ed in
    // afterwards so the split wins.
    mask_next        = mask_reg & ~split_release;
    do_take          = 1'b0;
    do_idle          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pick_found) do_take = 1'b1;
      end
      OWNED: begin
        if (split) begin
          mask_next = mask_next | grant_reg;
          do_take   = pick_found;
          do_idle   = !pick_found;
        end else if (!owner_req) begin
          do_take = pick_found;
          do_idle = !pick_found;
        end else if (HOLD_EN && (hold_reg == HOLD_LAST) && pick_found) begin
          do_take = 1'b1;
        end else if (hold_reg != HOLD_LAST) begin
          hold_next = hold_reg + CNT_W'(1);
        end
      end
      default: do_idle = 1'b1;
    endcase

    if (do_take) begin
      state_next       = OWNED;
      grant_next       = pick_onehot;
      grant_valid_next = 1'b1;
      sel_next         = pick_idx;
      hold_next        = '0;
      ptr_next         = SEL_W'((int'(pick_idx) + 1) % NUM_MASTERS);
    end else if (do_idle) begin
      state_next       = IDLE;
      grant_next       = '0;
      grant_valid_next = 1'b0;
      sel_next         = '0;
      hold_next        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      grant_reg       <= '0;
      grant_valid_reg <= 1'b0;
      sel_reg         <= '0;
      mask_reg        <= '0;
      hold_reg        <= '0;
      ptr_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      grant_valid_reg <= grant_valid_next;
      sel_reg         <= sel_next;
      mask_reg        <= mask_next;
      hold_reg        <= hold_next;
      ptr_reg         <= ptr_next;
    end
  end

  assign grant       = grant_reg;
  assign grant_valid = grant_valid_reg;
  assign m_select    = sel_reg;
  assign split_mask  = mask_reg;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_rr
//
// Scoreboard bench for bus_arbiter_rr (4 masters, tenure limit 4).
// The stimulus process drives inputs on the falling edge and pushes the
// expected outputs for the next rising edge. The expected outputs come from a
// reference model that is described in terms of owners and masks. Directed
// steps also carry literal grant/mask values.
// A monitor pops one entry per cycle, 1 time unit after the rising edge. It
// compares the entry against the DUT and checks the output invariants.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_rr;

  localparam int N     = 4;
  localparam int MH    = 4;
  localparam int SEL_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic             split = 1'b0;
  logic [N-1:0]     split_release = '0;
  logic [N-1:0]     grant;
  logic             grant_valid;
  logic [SEL_W-1:0] m_select;
  logic [N-1:0]     split_mask;

  always #5 clk = ~clk;

  bus_arbiter_rr #(.NUM_MASTERS(N), .MAX_HOLD(MH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .split         (split),
    .split_release (split_release),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .m_select      (m_select),
    .split_mask    (split_mask)
  );

  typedef struct {
    logic [N-1:0]     grant;
    logic             valid;
    logic [SEL_W-1:0] sel;
    logic [N-1:0]     mask;
    bit               spot;
    logic [N-1:0]     sgrant;
    logic [N-1:0]     smask;
    string            tag;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: owner index (-1 = none), last owner (-1 = after reset),
  // tenure cycles already served, and the parked set.
  int       m_owner = -1;
  int       m_last  = -1;
  int       m_hold  = 0;
  bit [N-1:0] m_mask = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic s,
                            input logic [N-1:0] rel, input logic rn);
    bit [N-1:0] new_mask;
    int win;
    int start;
    if (!rn) begin
      m_owner = -1;
      m_last  = -1;
      m_hold  = 0;
      m_mask  = '0;
      return;
    end
    new_mask = m_mask & ~rel;
    start = (m_last + 1) % N;
    win = -1;
    // The winner is the first unparked requester after the last owner,
    // excluding the current owner.
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (win < 0 && r[j] && !m_mask[j] && j != m_owner) win = j;
    end
    if (m_owner < 0) begin
      if (win >= 0) begin m_owner = win; m_last = win; m_hold = 0; end
    end else if (s || !r[m_owner]) begin
      if (s) new_mask[m_owner] = 1'b1;
      if (win >= 0) begin m_owner = win; m_last = win; m_hold = 0; end
      else begin m_owner = -1; m_hold = 0; end
    end else if (m_hold == MH - 1 && win >= 0) begin
      m_owner = win; m_last = win; m_hold = 0;
    end else if (m_hold < MH - 1) begin
      m_hold++;
    end
    m_mask = new_mask;
  endtask

  task automatic step(input logic [N-1:0] r, input logic s, input logic [N-1:0] rel,
                      input logic rn, input bit spot, input logic [N-1:0] sg,
                      input logic [N-1:0] sm, input string tag);
    exp_t e;
    @(negedge clk);
    req = r;
    split = s;
    split_release = rel;
    rst_n = rn;
    model_step(r, s, rel, rn);
    e.grant  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    e.valid  = (m_owner >= 0);
    e.sel    = (m_owner >= 0) ? SEL_W'(m_owner) : '0;
    e.mask   = m_mask;
    e.spot   = spot;
    e.sgrant = sg;
    e.smask  = sm;
    e.tag    = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: compares the DUT against one scoreboard entry per cycle.
  initial begin
    exp_t e;
    int   sidx;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant", 32'(grant), 32'(e.grant));
        check("grant_valid", 32'(grant_valid), 32'(e.valid));
        check("m_select", 32'(m_select), 32'(e.sel));
        check("split_mask", 32'(split_mask), 32'(e.mask));
        // Output invariants, independent of the model.
        check("onehot0", 32'($onehot0(grant)), 32'd1);
        check("valid_vs_grant", 32'(grant_valid), 32'(|grant));
        check("masked_granted", 32'(grant & split_mask), 32'd0);
        if (grant != '0) check("sel_vs_grant", 32'(grant), 32'(N'(1) << m_select));
        else             check("sel_idle", 32'(m_select), 32'd0);
        if (e.spot) begin
          sidx = 0;
          for (int i = 0; i < N; i++) if (e.sgrant[i]) sidx = i;
          check({"spot_grant_", e.tag}, 32'(grant), 32'(e.sgrant));
          check({"spot_mask_", e.tag}, 32'(split_mask), 32'(e.smask));
          check({"spot_sel_", e.tag}, 32'(m_select), 32'(sidx));
          check({"spot_valid_", e.tag}, 32'(grant_valid), 32'(e.sgrant != '0));
          $display("txn %-10s req=%b split=%b rel=%b -> grant=%b sel=%0d mask=%b",
                   e.tag, req, split, split_release, grant, m_select, split_mask);
        end
      end
    end
  end

  // Watchdog: the run is far shorter than this bound.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] one;
    logic [N-1:0] r;
    logic         s;
    logic [N-1:0] rel;
    logic         rn;
    one = 4'b0001;

    // Reset state.
    step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, "reset");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, "reset");

    // First grant after reset goes to the lowest requester at or above index 0.
    step(4'b1010, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0010, 4'b0000, "first");
    step(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, "drop");

    // All request, tenure limit 4: rotation with no gaps.
    step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, "reset");
    for (int k = 1; k <= 17; k++)
      step(4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, one << (((k - 1) / 4) % 4), 4'b0000, "rotate");
    step(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, "drop");

    // Split of owner 0: master 1 takes over, 0 stays parked until released.
    step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, "reset");
    step(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0001, 4'b0000, "own0");
    step(4'b0011, 1'b1, 4'b0000, 1'b1, 1'b1, 4'b0010, 4'b0001, "split0");
    for (int k = 0; k < 6; k++)
      step(4'b0011, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0010, 4'b0001, "parked");
    step(4'b0011, 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0010, 4'b0000, "release0");
    step(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0001, 4'b0000, "regrant0");

    // Split and release of owner 2 in the same cycle: the split wins.
    step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, "reset");
    step(4'b0100, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0100, 4'b0000, "own2");
    step(4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 4'b0000, 4'b0100, "splitrel2");
    step(4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b0000, 4'b0000, "release2");
    step(4'b0100, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0100, 4'b0000, "regrant2");

    // Reset during tenure of master 3 with master 0 parked.
    step(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, "reset");
    step(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0001, 4'b0000, "own0");
    step(4'b1001, 1'b1, 4'b0000, 1'b1, 1'b1, 4'b1000, 4'b0001, "split0");
    step(4'b1001, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b1000, 4'b0001, "own3");
    step(4'b1001, 1'b1, 4'b0001, 1'b0, 1'b1, 4'b0000, 4'b0000, "midreset");
    step(4'b1010, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0010, 4'b0000, "lowest");

    // Random run, checked against the model and the invariants every cycle.
    r = '0;
    for (int k = 0; k < 12000; k++) begin
      r   = r ^ N'($urandom & $urandom);
      s   = ($urandom_range(0, 19) == 0);
      rel = N'($urandom & $urandom & $urandom);
      rn  = ($urandom_range(0, 2999) != 0);
      step(r, s, rel, rn, 1'b0, '0, '0, "rand");
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 Parameter NUM_MASTERS, 4, number of requesting masters; legal range 2..16.
REQ-002 Parameter MAX_HOLD, 16, maximum tenure cycles before forced handover when others wait; 0 disables the limit.
REQ-003 Derived SEL_W = max(1, clog2(NUM_MASTERS)), width of m_select.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req  input  NUM_MASTERS  per-master bus request, level.
REQ-007 split  input  1  slave splits the current owner's transfer.
REQ-008 split_release  input  NUM_MASTERS  per-master split-resume strobe from the slave.
REQ-009 grant  output  NUM_MASTERS  one-hot or zero registered grant.
REQ-010 grant_valid  output  1  high while any grant bit is set.
REQ-011 m_select  output  SEL_W  index of the granted master; 0 when idle.
REQ-012 split_mask  output  NUM_MASTERS  masters currently parked by split.

Function
REQ-013 States are IDLE (no owner) and OWNED (exactly one grant bit set); grant, grant_valid and m_select are registered.
REQ-014 Eligible vector is req & ~split_mask; masked masters are never granted.
REQ-015 Arbitration is round-robin: search starts at (last_owner+1) mod NUM_MASTERS and takes the first eligible index; after reset the search starts at index 0.
REQ-016 IDLE: if any master is eligible, the winner's grant asserts on the next edge (1-cycle latency); otherwise stay IDLE.
REQ-017 OWNED: owner keeps the grant while req[owner] stays high and split is low, subject to REQ-019.
REQ-018 OWNED with req[owner] low: re-arbitrate among the others; the new grant appears on the next edge with no dead cycle, or the block goes IDLE if none is eligible.
REQ-019 Hold counter clears on each new grant and increments each OWNED cycle; at count MAX_HOLD-1 with another master eligible, the grant moves to the round-robin winner on the next edge; with no other eligible master, the owner keeps the grant and the counter saturates.
REQ-020 split high in OWNED: set split_mask[owner], drop the owner's grant, and grant the next eligible master (excluding owner) on the next edge, or go IDLE; split is ignored in IDLE.
REQ-021 split_release[i] clears split_mask[i] on the next edge; a release of an unmasked bit has no effect; multiple releases in one cycle are all honoured.
REQ-022 split and split_release for the owner in the same cycle: split wins and the mask bit ends set.
REQ-023 All requesters masked: IDLE, grant=0, m_select=0, grant_valid=0 until a release and request coincide.
REQ-024 grant is never multi-hot, and a master is never granted in the same cycle its request is sampled low.

Reset
REQ-025 With rst_n low at a clock edge: grant=0, grant_valid=0, m_select=0, split_mask=0, hold counter=0, round-robin pointer=0, state=IDLE.
REQ-026 Reset mid-tenure or mid-split takes effect on the next edge regardless of inputs, and all parked splits are discarded.

Verification
REQ-027 req=4'b1010 from IDLE after reset -> grant=4'b0010, m_select=1 one cycle later.
REQ-028 req=4'b1111 held, MAX_HOLD=4 -> grant rotates 0001,0010,0100,1000,0001 with a 4-cycle tenure each and no gap cycles.
REQ-029 Owner 0 split while req=4'b0011 -> next cycle grant=4'b0010, split_mask=4'b0001; master 0 is never granted until split_release[0] pulses, then it is granted after master 1 drops req.
REQ-030 Owner 2 gets split and split_release[2] in the same cycle with req=4'b0100 -> split_mask=4'b0100, grant=0, grant_valid=0.
REQ-031 rst_n low for one cycle during tenure of master 3 with split_mask=4'b0001 -> all outputs 0 next edge; the first grant after release goes to the lowest eligible index.
REQ-032 Properties: grant one-hot-or-zero, m_select matches grant index, and no masked master is granted; checked on every cycle of a random req/split/split_release run of at least 10k cycles.
